// File: rtl/ascon_din_buf.sv
// Two-entry staging buffer: packs host words into blocks for the ASCON controller.
// An assembly entry fills while a holding entry presents the previous block.
module ascon_din_buf #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128,
    localparam int unsigned WORDS  = BLOCK_W / WORD_W,
    localparam int unsigned CNT_W  = $clog2(WORDS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               wr_valid_i,
    input  logic [WORD_W-1:0]  wr_data_i,
    input  logic               wr_last_i,
    output logic               wr_ready_o,
    output logic               blk_valid_o,
    input  logic               blk_ready_i,
    output logic [BLOCK_W-1:0] blk_o,
    output logic [CNT_W-1:0]   blk_words_o,
    output logic               blk_last_o,
    output logic [1:0]         occupancy_o
);

    logic [BLOCK_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]   asm_cnt_q, asm_cnt_d;
    logic               asm_full_q, asm_full_d;
    logic               asm_last_q, asm_last_d;

    logic [BLOCK_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               hold_last_q, hold_last_d;
    logic               hold_valid_q, hold_valid_d;

    logic hold_free;
    logic transfer;
    logic pop;
    logic accept;

    assign wr_ready_o = ~asm_full_q;
    assign hold_free  = ~hold_valid_q | blk_ready_i;
    assign transfer   = asm_full_q & hold_free;
    assign pop        = hold_valid_q & blk_ready_i & ~transfer;
    // accept never coincides with transfer: transfer needs asm_full_q, accept needs it clear
    assign accept     = wr_valid_i & wr_ready_o;

    always_comb begin
        asm_d        = asm_q;
        asm_cnt_d    = asm_cnt_q;
        asm_full_d   = asm_full_q;
        asm_last_d   = asm_last_q;
        hold_d       = hold_q;
        hold_cnt_d   = hold_cnt_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;

        if (transfer) begin
            hold_d       = asm_q;
            hold_cnt_d   = asm_cnt_q;
            hold_last_d  = asm_last_q;
            hold_valid_d = 1'b1;
            asm_d        = '0;
            asm_cnt_d    = '0;
            asm_full_d   = 1'b0;
            asm_last_d   = 1'b0;
        end else if (pop) begin
            hold_valid_d = 1'b0;
        end

        if (accept) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (asm_cnt_q == CNT_W'(i)) begin
                    asm_d[i*WORD_W +: WORD_W] = wr_data_i;
                end
            end
            asm_cnt_d  = asm_cnt_q + CNT_W'(1);
            asm_full_d = (asm_cnt_d == CNT_W'(WORDS)) | wr_last_i;
            asm_last_d = wr_last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            asm_q        <= '0;
            asm_cnt_q    <= '0;
            asm_full_q   <= 1'b0;
            asm_last_q   <= 1'b0;
            hold_q       <= '0;
            hold_cnt_q   <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            asm_cnt_q    <= asm_cnt_d;
            asm_full_q   <= asm_full_d;
            asm_last_q   <= asm_last_d;
            hold_q       <= hold_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign blk_valid_o = hold_valid_q;
    assign blk_o       = hold_q;
    assign blk_words_o = hold_cnt_q;
    assign blk_last_o  = hold_last_q;
    assign occupancy_o = {1'b0, hold_valid_q} + {1'b0, asm_full_q};

endmodule
